// File: rtl/frv_pipeline_dispatch_mq_pkg.sv
// Dispatch stage shared definitions.
// Operand selects, FU one-hot indices, payload bundle.
package frv_pipeline_dispatch_mq_pkg;

  localparam int DIS_OPRA_RS1  = 0;
  localparam int DIS_OPRA_PCIM = 1;
  localparam int DIS_OPRA_CSRI = 2;
  localparam int DIS_OPRB_RS2  = 3;
  localparam int DIS_OPRB_IMM  = 4;
  localparam int DIS_OPRC_RS2  = 5;
  localparam int DIS_OPRC_CSRA = 6;
  localparam int DIS_OPRC_PCIM = 7;

  localparam int P_FU_ALU = 0;
  localparam int P_FU_MUL = 1;
  localparam int P_FU_LSU = 2;
  localparam int P_FU_CFU = 3;
  localparam int P_FU_CSR = 4;

  localparam int LSU_STORE = 4;

  localparam bit FWD_PRIO_YOUNGEST_FIRST = 1'b1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [4:0]  uop;
    logic [4:0]  fu;
    logic [1:0]  size;
    logic [31:0] instr;
    logic        trap;
  } dis_ctl_t;

  // Stores and conditional branches write no register.
  function automatic logic rd_suppressed(
    input logic [4:0] fu,
    input logic [4:0] uop
  );
    return (fu[P_FU_LSU] && uop[LSU_STORE]) ||
           (fu[P_FU_CFU] && (uop[4:3] == 2'b00));
  endfunction

endpackage

// File: rtl/frv_pipeline_dispatch_mq_fifo.sv
// In-order synchronous queue with flush.
// Head is read from storage, so it is registered.
module frv_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Next pointers and occupancy; flush empties the queue.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until counted.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/frv_pipeline_dispatch_mq.sv
// Dispatch: hazard check, forwarding, operand
// gather and an in-order queue ahead of execute.
module frv_pipeline_dispatch_mq
  import frv_pipeline_dispatch_mq_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NFWD  = 2,
  parameter  int DEPTH = 2,
  parameter  int CNT_W = 32,
  localparam int QCW   = $clog2(DEPTH + 1)
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               s2_p_valid,
  output logic               s2_p_busy,
  input  logic [4:0]         s2_rd,
  input  logic [4:0]         s2_rs1,
  input  logic [4:0]         s2_rs2,
  input  logic [31:0]        s2_imm,
  input  logic [31:0]        s2_pc,
  input  logic [4:0]         s2_uop,
  input  logic [4:0]         s2_fu,
  input  logic [7:0]         s2_opr_src,
  input  logic [1:0]         s2_size,
  input  logic [31:0]        s2_instr,
  input  logic               s2_trap,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [5*NFWD-1:0]  fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_wdata,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic               flush,
  output logic               s3_p_valid,
  input  logic               s3_p_busy,
  output logic [4:0]         s3_rd,
  output logic [31:0]        s3_pc,
  output logic [4:0]         s3_uop,
  output logic [4:0]         s3_fu,
  output logic [1:0]         s3_size,
  output logic [31:0]        s3_instr,
  output logic               s3_trap,
  output logic [XLEN-1:0]    s3_opr_a,
  output logic [XLEN-1:0]    s3_opr_b,
  output logic [XLEN-1:0]    s3_opr_c,
  output logic [QCW-1:0]     q_count,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int QW = $bits(dis_ctl_t) + 3 * XLEN;

  // Match vectors held in priority order: slot 0 wins.
  logic [NFWD-1:0]      m1_p, m2_p, rdy_p;
  logic [XLEN-1:0]      dat_p [NFWD];
  logic [XLEN-1:0]      rs1_v, rs2_v;
  logic                 hz1, hz2, hazard;

  for (genvar k = NFWD - 1; k >= 0; k--) begin : g_fwd
    localparam int P = FWD_PRIO_YOUNGEST_FIRST ? k : NFWD - 1 - k;
    assign m1_p[P]  = fwd_valid[k] && (s2_rs1 != 5'd0) &&
                      (fwd_rd[5*k +: 5] == s2_rs1);
    assign m2_p[P]  = fwd_valid[k] && (s2_rs2 != 5'd0) &&
                      (fwd_rd[5*k +: 5] == s2_rs2);
    assign rdy_p[P] = fwd_ready[k];
    assign dat_p[P] = fwd_wdata[XLEN*k +: XLEN];
  end

  // Priority forward select; last assignment is the winner.
  always_comb begin
    rs1_v = rs1_data;
    rs2_v = rs2_data;
    hz1   = 1'b0;
    hz2   = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (m1_p[i]) begin
        rs1_v = dat_p[i];
        hz1   = !rdy_p[i];
      end
      if (m2_p[i]) begin
        rs2_v = dat_p[i];
        hz2   = !rdy_p[i];
      end
    end
  end

  assign hazard = hz1 || hz2;

  logic [XLEN-1:0] pc_imm, csr_imm, csr_addr;
  logic [XLEN-1:0] opr_a, opr_b, opr_c;

  assign pc_imm   = XLEN'(s2_pc) + XLEN'(s2_imm);
  assign csr_imm  = {{(XLEN-5){s2_rs1[4]}}, s2_rs1};
  assign csr_addr = XLEN'({20'b0, s2_imm[31:20]});

  // Operand gather: OR of the selected sources.
  always_comb begin
    opr_a = ({XLEN{s2_opr_src[DIS_OPRA_RS1]}}  & rs1_v)   |
            ({XLEN{s2_opr_src[DIS_OPRA_PCIM]}} & pc_imm)  |
            ({XLEN{s2_opr_src[DIS_OPRA_CSRI]}} & csr_imm);
    opr_b = ({XLEN{s2_opr_src[DIS_OPRB_RS2]}}  & rs2_v)   |
            ({XLEN{s2_opr_src[DIS_OPRB_IMM]}}  & XLEN'(s2_imm));
    opr_c = ({XLEN{s2_opr_src[DIS_OPRC_RS2]}}  & rs2_v)   |
            ({XLEN{s2_opr_src[DIS_OPRC_CSRA]}} & csr_addr) |
            ({XLEN{s2_opr_src[DIS_OPRC_PCIM]}} & pc_imm);
  end

  dis_ctl_t ctl_in, ctl_out;

  // Control payload; rd cleared for non-writing ops.
  always_comb begin
    ctl_in.rd    = rd_suppressed(s2_fu, s2_uop) ? 5'd0 : s2_rd;
    ctl_in.pc    = s2_pc;
    ctl_in.uop   = s2_uop;
    ctl_in.fu    = s2_fu;
    ctl_in.size  = s2_size;
    ctl_in.instr = s2_instr;
    ctl_in.trap  = s2_trap;
  end

  logic          q_full, q_empty, q_push, q_pop;
  logic [QW-1:0] q_din, q_dout;

  assign q_push = s2_p_valid && !hazard && !q_full && !flush;
  assign q_pop  = !s3_p_busy;
  assign q_din  = {ctl_in, opr_a, opr_b, opr_c};

  frv_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_q (
    .clk_i   (g_clk),
    .rst_i   (g_reset),
    .flush_i (flush),
    .push_i  (q_push),
    .data_i  (q_din),
    .pop_i   (q_pop),
    .data_o  (q_dout),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign {ctl_out, s3_opr_a, s3_opr_b, s3_opr_c} = q_dout;

  assign s3_rd      = ctl_out.rd;
  assign s3_pc      = ctl_out.pc;
  assign s3_uop     = ctl_out.uop;
  assign s3_fu      = ctl_out.fu;
  assign s3_size    = ctl_out.size;
  assign s3_instr   = ctl_out.instr;
  assign s3_trap    = ctl_out.trap;
  assign s3_p_valid = !q_empty;
  assign s2_p_busy  = hazard || q_full;

  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating count of stalled valid-input cycles.
  always_comb begin
    bubble_d = bubble_q;
    if (s2_p_valid && hazard && !flush && !(&bubble_q))
      bubble_d = bubble_q + 1'b1;
  end

  // Bubble counter register.
  always_ff @(posedge g_clk) begin
    if (g_reset) bubble_q <= '0;
    else         bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_frv_pipeline_dispatch_mq.sv
// Directed bench for the dispatch stage.
// DEPTH=3, CNT_W=4 to reach full and saturation.
module tb_frv_pipeline_dispatch_mq;

  localparam logic [7:0] A_RS1  = 8'h01;
  localparam logic [7:0] A_PCIM = 8'h02;
  localparam logic [7:0] A_CSRI = 8'h04;
  localparam logic [7:0] B_RS2  = 8'h08;
  localparam logic [7:0] B_IMM  = 8'h10;
  localparam logic [7:0] C_CSRA = 8'h40;
  localparam logic [7:0] C_PCIM = 8'h80;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s2_p_valid, s2_p_busy;
  logic [4:0]  s2_rd, s2_rs1, s2_rs2, s2_uop, s2_fu;
  logic [31:0] s2_imm, s2_pc, s2_instr;
  logic [7:0]  s2_opr_src;
  logic [1:0]  s2_size;
  logic        s2_trap;
  logic [31:0] rs1_data, rs2_data;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_wdata;
  logic [1:0]  fwd_valid, fwd_ready;
  logic        flush;
  logic        s3_p_valid, s3_p_busy;
  logic [4:0]  s3_rd, s3_uop, s3_fu;
  logic [31:0] s3_pc, s3_instr;
  logic [1:0]  s3_size;
  logic        s3_trap;
  logic [31:0] s3_opr_a, s3_opr_b, s3_opr_c;
  logic [1:0]  q_count;
  logic [3:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  frv_pipeline_dispatch_mq #(
    .XLEN(32), .NFWD(2), .DEPTH(3), .CNT_W(4)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s2_p_valid(s2_p_valid), .s2_p_busy(s2_p_busy),
    .s2_rd(s2_rd), .s2_rs1(s2_rs1), .s2_rs2(s2_rs2),
    .s2_imm(s2_imm), .s2_pc(s2_pc), .s2_uop(s2_uop),
    .s2_fu(s2_fu), .s2_opr_src(s2_opr_src),
    .s2_size(s2_size), .s2_instr(s2_instr),
    .s2_trap(s2_trap),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rd(fwd_rd), .fwd_wdata(fwd_wdata),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .flush(flush),
    .s3_p_valid(s3_p_valid), .s3_p_busy(s3_p_busy),
    .s3_rd(s3_rd), .s3_pc(s3_pc), .s3_uop(s3_uop),
    .s3_fu(s3_fu), .s3_size(s3_size),
    .s3_instr(s3_instr), .s3_trap(s3_trap),
    .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b),
    .s3_opr_c(s3_opr_c),
    .q_count(q_count), .bubble_cnt(bubble_cnt)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic [31:0] imm,
                        input logic [31:0] pc,
                        input logic [4:0] uop,
                        input logic [4:0] fu,
                        input logic [7:0] src);
    s2_rd = rd; s2_rs1 = rs1; s2_rs2 = rs2;
    s2_imm = imm; s2_pc = pc; s2_uop = uop;
    s2_fu = fu; s2_opr_src = src;
  endtask

  initial begin
    g_reset = 1'b1; s2_p_valid = 1'b0; flush = 1'b0;
    s3_p_busy = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 5'b00001, 8'h00);
    s2_size = 2'b10; s2_instr = 32'h0; s2_trap = 1'b0;
    rs1_data = 0; rs2_data = 0;
    fwd_rd = 0; fwd_wdata = 0; fwd_valid = 0; fwd_ready = 0;
    step(); step();
    g_reset = 1'b0;
    #1;
    check("rst_count", q_count, 0);
    check("rst_valid", s3_p_valid, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_busy", s2_p_busy, 0);

    // forwarding priority: source 0 beats source 1
    set_op(3, 5, 0, 0, 0, 0, 5'b00001, A_RS1 | B_RS2);
    s2_instr = 32'hDEADBEEF; s2_trap = 1'b1;
    rs1_data = 32'h11; rs2_data = 32'h44;
    fwd_rd = {5'd5, 5'd5};
    fwd_wdata = {32'h33, 32'h22};
    fwd_valid = 2'b11; fwd_ready = 2'b11;
    s2_p_valid = 1'b1;
    #1 check("fwd_busy", s2_p_busy, 0);
    step();
    s2_p_valid = 1'b0; s2_trap = 1'b0;
    check("fwd_valid", s3_p_valid, 1);
    check("fwd_count", q_count, 1);
    check("fwd_a", s3_opr_a, 32'h22);
    check("fwd_b_r0", s3_opr_b, 32'h44);
    check("fwd_rd", s3_rd, 3);
    check("fwd_instr", s3_instr, 32'hDEADBEEF);
    check("fwd_trap", s3_trap, 1);
    s3_p_busy = 1'b0;
    step();
    s3_p_busy = 1'b1;
    check("fwd_drain", q_count, 0);

    // load-use hazard on rs2 via source 1
    set_op(4, 0, 7, 0, 0, 0, 5'b00001, B_RS2);
    fwd_rd = {5'd7, 5'd0};
    fwd_wdata = {32'h77, 32'h0};
    fwd_valid = 2'b10; fwd_ready = 2'b00;
    s2_p_valid = 1'b1;
    #1 check("hz_busy", s2_p_busy, 1);
    step(); step(); step();
    check("hz_bubble3", bubble_cnt, 3);
    check("hz_noenq", q_count, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("hz_flush_nocnt", bubble_cnt, 3);
    s2_p_valid = 1'b0;
    fwd_rd = {5'd7, 5'd7};
    fwd_valid = 2'b11; fwd_ready = 2'b01;
    #1 check("hz_winner_only", s2_p_busy, 0);
    fwd_rd = {5'd7, 5'd0};
    fwd_valid = 2'b10; fwd_ready = 2'b10;
    s2_p_valid = 1'b1;
    #1 check("hz_release", s2_p_busy, 0);
    step();
    s2_p_valid = 1'b0;
    check("hz_enq", q_count, 1);
    check("hz_b", s3_opr_b, 32'h77);
    check("hz_bubble_hold", bubble_cnt, 3);
    s3_p_busy = 1'b0;
    step();
    s3_p_busy = 1'b1;

    // operand composition and wrap
    fwd_valid = 2'b00;
    set_op(2, 0, 0, 32'hABC00004, 32'h1000, 0,
           5'b10000, A_PCIM | B_IMM | C_CSRA);
    s2_p_valid = 1'b1;
    step();
    set_op(2, 5'h10, 0, 32'h20, 32'hFFFFFFF0, 0,
           5'b10000, A_CSRI | C_PCIM);
    step();
    s2_p_valid = 1'b0;
    check("opr_count", q_count, 2);
    check("opr_a_pcimm", s3_opr_a, 32'hABC01004);
    check("opr_b_imm", s3_opr_b, 32'hABC00004);
    check("opr_c_csra", s3_opr_c, 32'h00000ABC);
    s3_p_busy = 1'b0;
    step();
    check("opr_a_csri", s3_opr_a, 32'hFFFFFFF0);
    check("opr_b_none", s3_opr_b, 32'h0);
    check("opr_c_wrap", s3_opr_c, 32'h10);
    step();
    s3_p_busy = 1'b1;
    check("opr_drain", q_count, 0);

    // fill to DEPTH, then drain in order
    set_op(1, 0, 0, 0, 0, 0, 5'b00001, B_IMM);
    for (int i = 0; i < 3; i++) begin
      s2_pc = 32'h100 + 32'(4 * i);
      s2_p_valid = 1'b1;
      step();
    end
    check("full_count", q_count, 3);
    s2_pc = 32'h10C;
    #1 check("full_busy", s2_p_busy, 1);
    step();
    check("full_hold", q_count, 3);
    s2_p_valid = 1'b0;
    s3_p_busy = 1'b0;
    check("ord_0", s3_pc, 32'h100);
    step();
    check("ord_1", s3_pc, 32'h104);
    check("ord_cnt2", q_count, 2);
    step();
    check("ord_2", s3_pc, 32'h108);
    s2_pc = 32'h110;
    s2_p_valid = 1'b1;
    step();
    s2_p_valid = 1'b0;
    check("enqdeq_cnt", q_count, 1);
    check("enqdeq_pc", s3_pc, 32'h110);
    step();
    s3_p_busy = 1'b1;
    check("ord_empty", q_count, 0);

    // flush with pending input
    s2_pc = 32'h200; s2_p_valid = 1'b1; step();
    s2_pc = 32'h204; step();
    check("fl_pre", q_count, 2);
    s2_pc = 32'h208;
    flush = 1'b1;
    step();
    flush = 1'b0;
    s2_p_valid = 1'b0;
    check("fl_count", q_count, 0);
    check("fl_valid", s3_p_valid, 0);
    step();
    check("fl_lost", q_count, 0);

    // rd suppression and r0 never forwarded
    set_op(9, 0, 0, 0, 0, 5'b10000, 5'b00100, A_RS1);
    rs1_data = 32'h55;
    fwd_rd = 10'd0;
    fwd_wdata = {32'h0, 32'hFF};
    fwd_valid = 2'b01; fwd_ready = 2'b00;
    #1 check("r0_nohz", s2_p_busy, 0);
    s2_p_valid = 1'b1;
    step();
    set_op(1, 0, 0, 0, 0, 5'b00010, 5'b01000, A_RS1);
    step();
    set_op(1, 0, 0, 0, 0, 5'b01000, 5'b01000, A_RS1);
    step();
    s2_p_valid = 1'b0;
    check("st_rd", s3_rd, 0);
    check("r0_a", s3_opr_a, 32'h55);
    s3_p_busy = 1'b0;
    step();
    check("br_rd", s3_rd, 0);
    step();
    check("jmp_rd", s3_rd, 1);
    step();
    s3_p_busy = 1'b1;

    // bubble counter saturation
    set_op(1, 6, 0, 0, 0, 0, 5'b00001, A_RS1);
    fwd_rd = {5'd0, 5'd6};
    fwd_valid = 2'b01; fwd_ready = 2'b00;
    s2_p_valid = 1'b1;
    repeat (20) step();
    check("sat_bubble", bubble_cnt, 4'hF);
    check("sat_noenq", q_count, 0);

    // reset mid-stream
    fwd_valid = 2'b00;
    step(); step();
    s2_p_valid = 1'b0;
    check("mid_pre", q_count, 2);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check("mid_count", q_count, 0);
    check("mid_valid", s3_p_valid, 0);
    check("mid_bubble", bubble_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
